// File: rtl/ldpc_pkg.sv
// Shared definitions for the read-side block sequencer.
//   ADDR_W_DEFAULT  : default width of addresses, lengths and remaining count
//   MAX_LEN_DEFAULT : largest accepted sequence length (longer requests clamp)
//   state_e         : sequencer FSM encoding
package ldpc_pkg;

    localparam int ADDR_W_DEFAULT  = 13;
    localparam int MAX_LEN_DEFAULT = 8191;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/updown_counter_ld.sv
// Loadable W-bit up/down counter.
//   clk_i      : rising-edge clock
//   reset_i    : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : step the count by one this cycle
//   up_i       : 1 = increment, 0 = decrement
//   count_o    : current count
module updown_counter_ld #(
    parameter int W = 13
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = up_i ? (count_q + W'(1)) : (count_q - W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_read_sequencer.sv
// Replays a stored block by issuing LEN read addresses, ascending (0..LEN-1)
// or descending (LEN-1..0), under a valid/ready handshake, then pulses done.
//   clk, reset          : clock, synchronous active-high reset
//   start, length,
//   descend             : request a sequence (sampled only in IDLE)
//   abort               : end the current sequence early (RUN only)
//   rd_ready            : downstream accepts rd_addr this cycle
//   rd_valid, rd_addr,
//   rd_last             : read beat presented downstream
//   busy, done          : RUN indicator, one-cycle end-of-sequence pulse
//   remaining           : beats not yet accepted
//   dbg_state           : current FSM state for observation
//
// Handshake: a beat transfers on any rising edge where rd_valid && rd_ready.
// rd_valid is a register, so it never depends combinationally on rd_ready;
// rd_addr/rd_last are stable while rd_valid is high and rd_ready is low.
module count_read_sequencer
    import ldpc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    input  logic              descend,
    input  logic              abort,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining,
    output state_e            dbg_state
);

    state_e      state_q;
    logic        rd_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        desc_q;

    logic [ADDR_W-1:0] len_c;
    logic [31:0]       len_wide;
    logic              accept;
    logic              final_beat;
    logic              start_idle;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] rem_cnt;

    // Widen before comparing so the clamp stays correct for any ADDR_W/MAX_LEN.
    assign len_wide   = 32'(length);
    assign len_c      = (len_wide > 32'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : length;

    assign accept     = rd_valid_q & rd_ready;
    assign final_beat = accept & (rem_cnt == ADDR_W'(1));
    assign start_idle = (state_q == IDLE) & start;

    // Address counter: the step after the final beat is suppressed so the
    // address never wraps and holds the last issued value.
    updown_counter_ld #(.W(ADDR_W)) u_addr_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (start_idle & (len_c != '0)),
        .load_val_i (descend ? (len_c - ADDR_W'(1)) : '0),
        .en_i       ((state_q == RUN) & accept & ~final_beat),
        .up_i       (~desc_q),
        .count_o    (addr_cnt)
    );

    // Remaining counter: loaded with the clamped length, counts accepted beats down.
    updown_counter_ld #(.W(ADDR_W)) u_rem_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (start_idle),
        .load_val_i (len_c),
        .en_i       ((state_q == RUN) & accept),
        .up_i       (1'b0),
        .count_o    (rem_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            desc_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        desc_q <= descend;
                        if (len_c != '0) begin
                            state_q    <= RUN;
                            rd_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            // Empty request: nothing to issue, just signal completion.
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort || final_beat) begin
                        state_q    <= FIN;
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_addr   = addr_cnt;
    assign rd_last   = rd_valid_q & (rem_cnt == ADDR_W'(1));
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_cnt;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_count_read_sequencer.sv
module tb_count_read_sequencer;
  import ldpc_pkg::*;

  localparam int AW = 13;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] length;
  logic          descend;
  logic          abort;
  logic          rd_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] remaining;
  state_e        dbg_state;

  always #5 clk = ~clk;

  count_read_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .descend   (descend),
    .abort     (abort),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  // Each record: inputs driven this cycle, outputs expected in this cycle
  // (i.e. resulting from the previous cycle's inputs).
  typedef struct {
    logic          st;
    logic [AW-1:0] len;
    logic          ds;
    logic          ab;
    logic          rdy;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic          e_last;
    logic          e_busy;
    logic          e_done;
    logic [AW-1:0] e_rem;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic st, input int len, input logic ds, input logic ab,
                                  input logic rdy, input logic ev, input int ea, input logic el,
                                  input logic eb, input logic ed, input int er);
    vec_t v;
    v.st = st; v.len = AW'(len); v.ds = ds; v.ab = ab; v.rdy = rdy;
    v.e_valid = ev; v.e_addr = AW'(ea); v.e_last = el; v.e_busy = eb; v.e_done = ed; v.e_rem = AW'(er);
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    start = 1'b0; length = '0; descend = 1'b0; abort = 1'b0; rd_ready = 1'b0;
  endtask

  // Reference model: one sequence is the list of addresses in issue order.
  // Outputs are checked each cycle against the head of the expected queue.
  task automatic run_seq(input int len, input bit desc, input int abort_cyc,
                         input bit full_ready, input int start_cyc, input string tag);
    logic [AW-1:0] exp_q[$];
    int cyc;
    bit fin;
    for (int i = 0; i < len; i++)
      exp_q.push_back(desc ? AW'(len - 1 - i) : AW'(i));
    @(negedge clk);
    start = 1'b1; length = AW'(len); descend = desc; abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < len * 4 + 20) begin
      chk({tag, " rd_valid"}, rd_valid, 1);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " rd_addr"}, rd_addr, exp_q[0]);
      chk({tag, " rd_last"}, rd_last, exp_q.size() == 1);
      chk({tag, " remaining"}, remaining, exp_q.size());
      chk({tag, " done_low"}, done, 0);
      rd_ready = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
      abort    = (cyc == abort_cyc);
      start    = (cyc == start_cyc);
      if (rd_ready) void'(exp_q.pop_front());
      if (exp_q.size() == 0 || abort) fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    drive_idle();
    if (!fin) begin
      chk({tag, " timeout"}, 0, 1);
    end else begin
      chk({tag, " fin_done"}, done, 1);
      chk({tag, " fin_valid"}, rd_valid, 0);
      chk({tag, " fin_busy"}, busy, 0);
      chk({tag, " fin_remaining"}, remaining, exp_q.size());
      if (!desc && abort_cyc < 0 && len > 0)
        chk({tag, " fin_addr_hold"}, rd_addr, len - 1);
    end
    @(negedge clk);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " idle_state"}, dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset rd_last", rd_last, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset remaining", remaining, 0);
    chk("reset state", dbg_state, IDLE);
    reset = 1'b0;

    // ascending, length 4, ready held high
    add_vec(1, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 4);
    add_vec(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 3);
    add_vec(0, 0, 0, 0, 1,  1, 2, 0, 1, 0, 2);
    add_vec(0, 0, 0, 0, 1,  1, 3, 1, 1, 0, 1);
    add_vec(0, 0, 0, 0, 0,  0, 3, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0);
    // descending, length 3, ready 1,0,1,0,1; start in FIN is ignored
    add_vec(1, 3, 1, 0, 0,  0, 3, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1,  1, 2, 0, 1, 0, 3);
    add_vec(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 2);
    add_vec(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 2);
    add_vec(0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 1);
    add_vec(0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 1);
    add_vec(1, 5, 0, 1, 0,  0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
    // zero length: no beats, done pulse only; abort in FIN ignored
    add_vec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    // abort after 3 accepts, ready low on the abort cycle
    add_vec(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 10);
    add_vec(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 9);
    add_vec(0, 0, 0, 0, 1,  1, 2, 0, 1, 0, 8);
    add_vec(0, 0, 0, 1, 0,  1, 3, 0, 1, 0, 7);
    add_vec(0, 0, 0, 0, 0,  0, 3, 0, 0, 1, 7);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d rd_addr", i), rd_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d rd_last", i), rd_last, vecs[i].e_last);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d remaining", i), remaining, vecs[i].e_rem);
      start = vecs[i].st; length = vecs[i].len; descend = vecs[i].ds;
      abort = vecs[i].ab; rd_ready = vecs[i].rdy;
    end
    @(negedge clk);
    drive_idle();
    chk("post-abort state", dbg_state, IDLE);

    // reset mid-run at remaining=5; start asserted during reset is ignored
    @(negedge clk);
    start = 1'b1; length = AW'(8); descend = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst remaining", remaining, 5);
    chk("midrst rd_addr", rd_addr, 3);
    reset = 1'b1; start = 1'b1; length = AW'(6);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; rd_ready = 1'b0;
    chk("midrst rd_valid", rd_valid, 0);
    chk("midrst rd_addr0", rd_addr, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst remaining0", remaining, 0);
    chk("midrst state", dbg_state, IDLE);
    @(negedge clk);
    chk("midrst start_ignored valid", rd_valid, 0);
    chk("midrst start_ignored done", done, 0);
    chk("midrst start_ignored state", dbg_state, IDLE);

    // boundary: full-length ascending, start pulsed mid-run
    run_seq(8191, 1'b0, -1, 1'b1, 100, "maxlen");
    // single beat, both directions
    run_seq(1, 1'b0, -1, 1'b0, -1, "len1_up");
    run_seq(1, 1'b1, -1, 1'b0, -1, "len1_dn");

    // randomized sequences with random backpressure and occasional abort
    for (int r = 0; r < 25; r++) begin
      int len;
      int ab;
      len = $urandom_range(1, 24);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_seq(len, 1'($urandom_range(0, 1)), ab, 1'b0,
              $urandom_range(0, len + 2), $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
